// File: rtl/irq_controller.sv
// P0 interrupt controller: rising-edge capture into pending bits, mask, fixed
// lowest-index priority and a single-level req/ack/done handshake with the core.
module irq_controller #(
  parameter int unsigned        VEC_W    = 10,
  parameter logic [VEC_W-1:0]   VEC_BASE = 10'h3F0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_irq_in,
  input  logic             i_mask_we,
  input  logic [7:0]       i_mask_in,
  input  logic             i_int_ack,
  input  logic             i_int_done,
  output logic             o_int_req,
  output logic [2:0]       o_irq_id,
  output logic [VEC_W-1:0] o_vector,
  output logic [7:0]       o_pending,
  output logic [7:0]       o_mask_out,
  output logic             o_in_service
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e             r_state;
  logic [7:0]         r_prev;
  logic [7:0]         r_pending;
  logic [7:0]         r_mask;
  logic               r_int_req;
  logic               r_in_service;
  logic [2:0]         r_irq_id;
  logic [VEC_W-1:0]   r_vector;

  state_e             w_state_d;
  logic [7:0]         w_rise;
  logic [7:0]         w_active;
  logic [7:0]         w_clr;
  logic [7:0]         w_pending_d;
  logic [2:0]         w_win_id;
  logic [2:0]         w_irq_id_d;
  logic               w_int_req_d;
  logic               w_in_service_d;

  assign w_rise      = i_irq_in & ~r_prev;
  assign w_active    = r_pending & r_mask;
  // A rise on the line being acknowledged survives the clear.
  assign w_pending_d = (r_pending & ~w_clr) | w_rise;

  always_comb begin
    w_win_id = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_active[i]) w_win_id = 3'(i);
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_irq_id_d     = r_irq_id;
    w_int_req_d    = r_int_req;
    w_in_service_d = r_in_service;
    w_clr          = '0;
    unique case (r_state)
      StIdle: begin
        if (|w_active) begin
          w_irq_id_d  = w_win_id;
          w_int_req_d = 1'b1;
          w_state_d   = StReq;
        end
      end
      StReq: begin
        if (i_int_ack) begin
          w_clr[r_irq_id] = 1'b1;
          w_int_req_d     = 1'b0;
          w_in_service_d  = 1'b1;
          w_state_d       = StService;
        end else if (!r_mask[r_irq_id]) begin
          w_int_req_d = 1'b0;
          w_state_d   = StIdle;
        end
      end
      StService: begin
        if (i_int_done) begin
          w_in_service_d = 1'b0;
          w_state_d      = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_prev       <= 8'hFF;
      r_pending    <= 8'h00;
      r_mask       <= 8'h00;
      r_int_req    <= 1'b0;
      r_in_service <= 1'b0;
      r_irq_id     <= 3'd0;
      r_vector     <= VEC_BASE;
    end else begin
      r_state      <= w_state_d;
      r_prev       <= i_irq_in;
      r_pending    <= w_pending_d;
      r_int_req    <= w_int_req_d;
      r_in_service <= w_in_service_d;
      r_irq_id     <= w_irq_id_d;
      r_vector     <= VEC_BASE + VEC_W'(w_irq_id_d);
      if (i_mask_we) r_mask <= i_mask_in;
    end
  end

  assign o_int_req    = r_int_req;
  assign o_irq_id     = r_irq_id;
  assign o_vector     = r_vector;
  assign o_pending    = r_pending;
  assign o_mask_out   = r_mask;
  assign o_in_service = r_in_service;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed table, corner-case sequences and random
// traffic compared against a behavioural model of the interrupt rules.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       int_ack;
  logic       int_done;
  logic       int_req;
  logic [2:0] irq_id;
  logic [9:0] vector;
  logic [7:0] pending;
  logic [7:0] mask_out;
  logic       in_service;

  always #5 clk = ~clk;

  irq_controller #(
    .VEC_W   (10),
    .VEC_BASE(10'h3F0)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_irq_in    (irq_in),
    .i_mask_we   (mask_we),
    .i_mask_in   (mask_in),
    .i_int_ack   (int_ack),
    .i_int_done  (int_done),
    .o_int_req   (int_req),
    .o_irq_id    (irq_id),
    .o_vector    (vector),
    .o_pending   (pending),
    .o_mask_out  (mask_out),
    .o_in_service(in_service)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: what the core should see, tracked as plain integers.
  int m_prev, m_pend, m_mask, m_id;
  bit m_waiting;   // request raised, core has not accepted it yet
  bit m_handling;  // handler running

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int lowest_set(input int v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 'hFF; m_pend = 0; m_mask = 0; m_id = 0;
    m_waiting = 0; m_handling = 0;
  endtask

  task automatic model_edge();
    int rise, accepted, cand;
    rise     = int'(irq_in) & ~m_prev & 'hFF;
    accepted = 0;
    if (m_handling) begin
      if (int_done) m_handling = 0;
    end else if (m_waiting) begin
      if (int_ack) begin
        accepted = 1 << m_id;
        m_waiting = 0;
        m_handling = 1;
      end else if (((m_mask >> m_id) & 1) == 0) begin
        m_waiting = 0;
      end
    end else begin
      cand = lowest_set(m_pend & m_mask);
      if (cand >= 0) begin
        m_id = cand;
        m_waiting = 1;
      end
    end
    m_pend = (m_pend & ~accepted) | rise;
    if (mask_we) m_mask = int'(mask_in);
    m_prev = int'(irq_in);
  endtask

  task automatic check_model();
    chk("int_req", 32'(int_req), 32'(m_waiting));
    chk("in_service", 32'(in_service), 32'(m_handling));
    chk("irq_id", 32'(irq_id), 32'(m_id));
    chk("vector", 32'(vector), 32'('h3F0 + m_id));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("mask_out", 32'(mask_out), 32'(m_mask));
  endtask

  task automatic step(input logic [7:0] irq, input logic we, input logic [7:0] mi,
                      input logic ack, input logic done);
    irq_in = irq; mask_we = we; mask_in = mi; int_ack = ack; int_done = done;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    mask_we = 1'b0; int_ack = 1'b0; int_done = 1'b0;
  endtask

  typedef struct {
    logic [7:0] irq;
    logic       we;
    logic [7:0] mi;
    logic       ack;
    logic       done;
    logic       req;
    logic [2:0] id;
    logic       svc;
    logic [7:0] pend;
    logic [7:0] mask;
  } vec_t;

  vec_t tbl[26];

  initial begin
    tbl[0]  = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF};
    tbl[1]  = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 8'hFF};
    tbl[2]  = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 8'hFF};
    tbl[3]  = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 8'hFF};
    tbl[4]  = '{8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 8'hFF};
    tbl[5]  = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 8'hFF};
    tbl[6]  = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00, 8'hFF};
    tbl[7]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'hFF};
    tbl[8]  = '{8'hA4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'hA4, 8'hFF};
    tbl[9]  = '{8'hA4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'hA4, 8'hFF};
    tbl[10] = '{8'hA4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'hA0, 8'hFF};
    tbl[11] = '{8'hA4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'hA0, 8'hFF};
    tbl[12] = '{8'hA4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'hA0, 8'hFF};
    tbl[13] = '{8'hA4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 8'h80, 8'hFF};
    tbl[14] = '{8'hA4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h80, 8'hFF};
    tbl[15] = '{8'hA4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 8'h80, 8'hFF};
    tbl[16] = '{8'hA4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 8'h00, 8'hFF};
    tbl[17] = '{8'hA4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 8'h00, 8'hFF};
    tbl[18] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 8'h00};
    tbl[19] = '{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h01, 8'h00};
    tbl[20] = '{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h01, 8'h00};
    tbl[21] = '{8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h01, 8'h01};
    tbl[22] = '{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01, 8'h01};
    tbl[23] = '{8'h01, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01, 8'h00};
    tbl[24] = '{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h01, 8'h00};
    tbl[25] = '{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h01, 8'h00};

    // Reset with all lines high; nothing may trigger after release.
    rst_n = 1'b0; irq_in = 8'hFF; mask_we = 1'b0; mask_in = 8'h00;
    int_ack = 1'b0; int_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst int_req", 32'(int_req), 32'd0);
    chk("rst in_service", 32'(in_service), 32'd0);
    chk("rst irq_id", 32'(irq_id), 32'd0);
    chk("rst vector", 32'(vector), 32'h3F0);
    chk("rst pending", 32'(pending), 32'h00);
    chk("rst mask", 32'(mask_out), 32'h00);
    rst_n = 1'b1;
    repeat (10) step(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle pending", 32'(pending), 32'h00);
    chk("idle int_req", 32'(int_req), 32'd0);
    chk("idle vector", 32'(vector), 32'h3F0);

    // Directed table: single irq, priority chain, mask/withdraw.
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].irq, tbl[i].we, tbl[i].mi, tbl[i].ack, tbl[i].done);
      chk($sformatf("tbl%0d int_req", i), 32'(int_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d irq_id", i), 32'(irq_id), 32'(tbl[i].id));
      chk($sformatf("tbl%0d vector", i), 32'(vector), 32'h3F0 + 32'(tbl[i].id));
      chk($sformatf("tbl%0d in_service", i), 32'(in_service), 32'(tbl[i].svc));
      chk($sformatf("tbl%0d pending", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d mask", i), 32'(mask_out), 32'(tbl[i].mask));
    end

    // Asynchronous reset while a request is outstanding.
    step(8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
    step(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre-reset int_req", 32'(int_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst int_req", 32'(int_req), 32'd0);
    chk("async rst pending", 32'(pending), 32'h00);
    chk("async rst mask", 32'(mask_out), 32'h00);
    chk("async rst vector", 32'(vector), 32'h3F0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // No nesting: line 0 rises while line 4 is in service.
    step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    step(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
    step(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("nest req id4", 32'(irq_id), 32'd4);
    step(8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    step(8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("nest pending", 32'(pending), 32'h01);
    repeat (3) begin
      step(8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("nest held off", 32'(int_req), 32'd0);
    end
    step(8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("nest gap", 32'(int_req), 32'd0);
    step(8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("nest next req", 32'(int_req), 32'd1);
    chk("nest next id", 32'(irq_id), 32'd0);
    step(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

    // New rise on line 1 on the same edge its ack is accepted.
    step(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("setclr req id1", 32'(irq_id), 32'd1);
    step(8'h02, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("setclr pending", 32'(pending), 32'h02);
    chk("setclr in_service", 32'(in_service), 32'd1);
    step(8'h02, 1'b0, 8'h00, 1'b0, 1'b1);
    step(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("setclr second req", 32'(int_req), 32'd1);
    chk("setclr second id", 32'(irq_id), 32'd1);

    // Random traffic against the model, with one mid-run reset.
    for (int c = 0; c < 800; c++) begin
      logic [7:0] nirq;
      nirq = irq_in;
      if ($urandom_range(3) == 0) nirq = 8'($urandom);
      if (c == 400) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      step(nirq, ($urandom_range(15) == 0), 8'($urandom),
           ($urandom_range(2) == 0), ($urandom_range(3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller for port P0, the input port dedicated to interrupts. It takes the registered 8-bit P0 value from the input stage and detects rising edges on each bit. It latches these as pending requests, applies a software-writable mask, and presents one prioritised, vectored request to the processor core. It runs a request/acknowledge/return handshake with the core and supports one interrupt in service at a time, with no nesting.

## Interface
Parameters:
- VEC_W, 10, width of the vector output (matches the program-counter width).
- VEC_BASE, 10'h3F0, vector address for line 0. Line k vectors to VEC_BASE + k.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq_in  input  8  registered P0 value from the input stage. Bit k is interrupt line k.
- mask_we  input  1  write strobe for the mask register.
- mask_in  input  8  new mask value. Bit k = 1 enables line k.
- int_ack  input  1  core accepts the current request; single-cycle pulse.
- int_done  input  1  core executed return-from-interrupt; single-cycle pulse.
- int_req  output  1  interrupt request to the core (registered).
- irq_id  output  3  index of the requested or in-service line (registered).
- vector  output  VEC_W  VEC_BASE + irq_id, zero-extended (registered).
- pending  output  8  pending-request register.
- mask_out  output  8  current mask register.
- in_service  output  1  high while a handler is running.

## Operation
- Edge detect:
  - prev register holds last cycle's irq_in.
  - rise = irq_in & ~prev.
  - Levels are ignored; only 0->1 transitions count.
- Pending:
  - Each edge: pending <= (pending & ~clr) | rise.
  - clr is the one-hot of irq_id on an accepted int_ack, otherwise 0.
  - Set wins over clear on the same bit in the same cycle.
- Mask:
  - On mask_we, mask <= mask_in, effective from the next edge.
  - Masked lines still accumulate in pending.
- Priority: the lowest index among (pending & mask) wins.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if (pending & mask) != 0, latch the winning id into irq_id and vector, set int_req, go to REQ.
  - REQ, int_req=1: irq_id is frozen. A newly pending higher-priority line does not replace it.
    - int_ack=1: clear pending[irq_id], drop int_req, set in_service, go to SERVICE.
    - Otherwise, if mask[irq_id]=0 (mask write took effect): withdraw. Drop int_req, go to IDLE, keep pending[irq_id]. This is checked after int_ack, so int_ack wins over a same-cycle withdraw.
  - SERVICE, in_service=1: no requests are raised. On int_done, clear in_service and go to IDLE.
- Ignored inputs:
  - int_ack outside REQ is ignored.
  - int_done outside SERVICE is ignored.
- vector and irq_id hold their last values in IDLE.

## Timing
- Reset values while reset=0:
  - int_req=0, in_service=0, irq_id=0, vector=VEC_BASE.
  - pending=8'h00, mask=8'h00, prev=8'hFF, state IDLE.
  - prev=FF means lines already high at reset release do not trigger.
- Reset asserted mid-operation (REQ or SERVICE) clears everything immediately and asynchronously. Pending requests are lost.
- Latency:
  - Edge E0 samples irq_in[k]=1 with prev[k]=0: pending[k]=1 after E0.
  - Edge E1: int_req=1, with irq_id and vector valid, if mask[k]=1.
  - Add one cycle for the input-stage register ahead of this block.
- Acknowledge: after the edge sampling int_ack=1, int_req=0, in_service=1 and pending[irq_id]=0.
- Return:
  - After the edge sampling int_done=1, the block is in IDLE.
  - A queued enabled request raises int_req at the following edge, so there is at least one cycle of int_req=0 between handlers.
- Mask write in REQ clearing the requested line: int_req drops one edge after the write edge.
- A line held high generates exactly one pending event. A second event requires a low cycle first.

## Test plan
- Reset/idle: reset=0 with irq_in=FF, then release and hold irq_in=FF for 10 cycles. Expect pending=00, int_req=0, vector=3F0.
- Single IRQ:
  - Stimulus: mask=FF, irq_in 00->08.
  - Expect pending=08 one edge later, then int_req=1, irq_id=3, vector=3F3.
  - int_ack: expect int_req=0, in_service=1, pending=00.
  - int_done: expect in_service=0.
- Priority:
  - Stimulus: mask=FF, irq_in 00->A4 in one cycle.
  - Expect irq_id=2 first, then 5 after ack/done, then 7.
  - Each int_req must be preceded by at least one int_req=0 cycle.
- Masking/withdraw:
  - mask=00, irq_in 00->01: expect pending=01, int_req=0.
  - Write mask=01: expect int_req=1, irq_id=0.
  - Write mask=00 in REQ: expect int_req=0 next edge, pending=01 retained.
- No nesting: in SERVICE for line 4, raise irq_in bit 0. Expect int_req=0 until int_done, then int_req=1 with irq_id=0.
- Simultaneous set/clear: a new rising edge on line 1 on the same edge int_ack accepts line 1. Expect pending=02 after the edge, then a second request for line 1 after int_done.
